program_load_sequencer: RTL and testbench
=========================================

PROGRAM_LOAD_SEQUENCER -- requirements
Module: program_load_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8; width of the instruction-memory and data-memory word addresses.
REQ-002 SHALL have parameter IMEM_DEPTH, default 256; instruction-memory capacity in words, at most 2^ADDR_W.
REQ-003 SHALL have parameter DMEM_DEPTH, default 256; data-memory capacity in words, at most 2^ADDR_W.
REQ-004 SHALL have port clk, input, 1 bit; single clock, all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit; synchronous, active-high reset.
REQ-006 SHALL have port start_signal, input, 1 bit; level request to end loading and begin execution.
REQ-007 SHALL have port add_into, input, 1 bit; load target select, 0 = instruction memory, 1 = data memory.
REQ-008 SHALL have the following word-input ports:
- new_instruction, input, 32 bits; word to load.
- in_valid, input, 1 bit; new_instruction is valid this cycle.
REQ-009 SHALL have port end_signal, input, 1 bit; processor reports program completion.
REQ-010 SHALL have the following instruction-memory write-port outputs:
- imem_we, output, 1 bit.
- imem_addr, output, ADDR_W bits.
- imem_wdata, output, 32 bits.
REQ-011 SHALL have the following data-memory write-port outputs:
- dmem_we, output, 1 bit.
- dmem_addr, output, ADDR_W bits.
- dmem_wdata, output, 32 bits.
REQ-012 SHALL have the following size outputs:
- prog_size, output, ADDR_W+1 bits; instruction words loaded.
- data_size, output, ADDR_W+1 bits; data words loaded.
REQ-013 SHALL have the following status outputs:
- cpu_run, output, 1 bit; processor enable.
- done, output, 1 bit; execution finished.
- overflow, output, 1 bit; sticky, a write was dropped because its memory was full.
- run_cycles, output, 32 bits; clock cycles spent in RUN.
- state, output, 3 bits; current state encoding, for debug.

Function
REQ-014 SHALL implement the FSM states LOAD_I=0, LOAD_D=1, RUN=2, HALT=3; state SHALL output the current encoding.
REQ-015 In LOAD_I with add_into=1, the FSM SHALL go to LOAD_D on the next edge; the switch is one-way, and add_into returning to 0 SHALL be ignored.
REQ-016 In LOAD_I or LOAD_D with start_signal=1, the FSM SHALL go to RUN on the next edge if prog_size>0, else to HALT.
REQ-017 start_signal SHALL take priority over add_into when both are asserted in the same cycle.
REQ-018 In RUN with end_signal=1, the FSM SHALL go to HALT; HALT SHALL be held until reset.
REQ-019 An accepted word SHALL be one with in_valid=1 in LOAD_I or LOAD_D; in_valid in RUN or HALT SHALL be ignored.
REQ-020 An accepted word SHALL be routed by the current state, not by add_into: LOAD_I to imem, LOAD_D to dmem.
REQ-021 Write latency SHALL be 1 cycle: the write-enable, address and data outputs are registered and asserted on the edge after acceptance, for exactly one cycle per word.
REQ-022 The write address SHALL equal the pre-increment pointer; the pointer and the matching size output SHALL increment by 1 with each issued write.
REQ-023 A word accepted in the same cycle as start_signal or the add_into switch SHALL still be written to the current state's memory.
REQ-024 Full condition: if the pointer equals IMEM_DEPTH (or DMEM_DEPTH), the word SHALL be dropped, we SHALL stay 0, the size SHALL saturate, and overflow SHALL set and remain set until reset.
REQ-025 Back-to-back in_valid SHALL be accepted every cycle with no stall.
REQ-026 cpu_run SHALL be 1 only while in RUN, registered, and high on the first RUN cycle.
REQ-027 done SHALL be 1 only while in HALT.
REQ-028 run_cycles SHALL increment once per cycle while in RUN, saturate at 32'hFFFFFFFF, and freeze in HALT.
REQ-029 end_signal outside RUN SHALL be ignored.

Reset
REQ-030 On reset=1 at a rising edge, the block SHALL enter LOAD_I from any state, including mid-load and mid-RUN.
REQ-031 On reset, the following outputs SHALL all be zeroed:
- state, pointers, prog_size, data_size
- imem_we, dmem_we, all addresses and wdata
- cpu_run, done, overflow, run_cycles
REQ-032 On reset, memory contents SHALL NOT be cleared.
REQ-033 reset SHALL take priority over all other inputs in the same cycle.

Verification
REQ-034 Load 24 instruction words, then 7 data words, then start -> imem addresses 0..23, dmem addresses 0..6, prog_size=24, data_size=7, cpu_run=1 on the cycle after start.
REQ-035 start with no words loaded -> next state HALT, done=1, cpu_run never asserted, run_cycles=0.
REQ-036 With IMEM_DEPTH=4, send 6 instruction words -> 4 writes at addresses 0..3, prog_size=4, overflow=1.
REQ-037 In RUN, assert end_signal after 50 cycles -> HALT, run_cycles=50, done=1; a later in_valid causes no writes.
REQ-038 Assert reset mid-RUN with prog_size=10 -> next cycle state=LOAD_I, all outputs 0; a reload writes again from address 0.
REQ-039 Assert add_into with in_valid in the same cycle, then add_into=0 with in_valid -> first word to imem, second to dmem address 0, state stays LOAD_D.

Source files
------------

// File: rtl/program_load_sequencer.sv
// Program/data loader that streams words into instruction and data memories,
// then hands control to the processor and counts cycles until it reports completion.
module program_load_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_signal,
  input  logic              add_into,
  input  logic [31:0]       new_instruction,
  input  logic              in_valid,
  input  logic              end_signal,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [ADDR_W:0]   prog_size,
  output logic [ADDR_W:0]   data_size,
  output logic              cpu_run,
  output logic              done,
  output logic              overflow,
  output logic [31:0]       run_cycles,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    LOAD_I = 3'd0,
    LOAD_D = 3'd1,
    RUN    = 3'd2,
    HALT   = 3'd3
  } state_t;

  // Pointer values at which a memory is full; pointers are one bit wider than addresses.
  localparam logic [ADDR_W:0] IMEM_LIMIT = (ADDR_W+1)'(IMEM_DEPTH);
  localparam logic [ADDR_W:0] DMEM_LIMIT = (ADDR_W+1)'(DMEM_DEPTH);
  localparam logic [ADDR_W:0] PTR_ZERO   = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] PTR_ONE    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [31:0]     RUN_MAX    = 32'hFFFF_FFFF;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     iptr_q, iptr_d;
  logic [ADDR_W:0]     dptr_q, dptr_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
  logic [31:0]         dmem_wdata_q, dmem_wdata_d;
  logic                cpu_run_q, cpu_run_d;
  logic                done_q, done_d;
  logic                overflow_q, overflow_d;
  logic [31:0]         run_cycles_q, run_cycles_d;
  logic                accept_s;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LOAD_I;
      iptr_q       <= PTR_ZERO;
      dptr_q       <= PTR_ZERO;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= {ADDR_W{1'b0}};
      imem_wdata_q <= 32'd0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= {ADDR_W{1'b0}};
      dmem_wdata_q <= 32'd0;
      cpu_run_q    <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      run_cycles_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      iptr_q       <= iptr_d;
      dptr_q       <= dptr_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      cpu_run_q    <= cpu_run_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  // Next-state, write issue and counters
  always_comb begin
    state_d      = state_q;
    iptr_d       = iptr_q;
    dptr_d       = dptr_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    dmem_we_d    = 1'b0;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    overflow_d   = overflow_q;
    run_cycles_d = run_cycles_q;
    accept_s     = in_valid && ((state_q == LOAD_I) || (state_q == LOAD_D));

    case (state_q)
      LOAD_I: begin
        // Words are routed by the current state, so a word arriving with add_into still lands in imem.
        if (accept_s) begin
          if (iptr_q == IMEM_LIMIT) begin
            overflow_d = 1'b1;
          end else begin
            imem_we_d    = 1'b1;
            imem_addr_d  = iptr_q[ADDR_W-1:0];
            imem_wdata_d = new_instruction;
            iptr_d       = iptr_q + PTR_ONE;
          end
        end else begin
          iptr_d = iptr_q;
        end
        if (start_signal) begin
          state_d = (iptr_q != PTR_ZERO) ? RUN : HALT;
        end else if (add_into) begin
          state_d = LOAD_D;
        end else begin
          state_d = LOAD_I;
        end
      end
      LOAD_D: begin
        if (accept_s) begin
          if (dptr_q == DMEM_LIMIT) begin
            overflow_d = 1'b1;
          end else begin
            dmem_we_d    = 1'b1;
            dmem_addr_d  = dptr_q[ADDR_W-1:0];
            dmem_wdata_d = new_instruction;
            dptr_d       = dptr_q + PTR_ONE;
          end
        end else begin
          dptr_d = dptr_q;
        end
        if (start_signal) begin
          state_d = (iptr_q != PTR_ZERO) ? RUN : HALT;
        end else begin
          state_d = LOAD_D;
        end
      end
      RUN: begin
        if (run_cycles_q != RUN_MAX) begin
          run_cycles_d = run_cycles_q + 32'd1;
        end else begin
          run_cycles_d = run_cycles_q;
        end
        if (end_signal) begin
          state_d = HALT;
        end else begin
          state_d = RUN;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = LOAD_I;
      end
    endcase

    // Status flags are registered from the next state so cpu_run is high on the first RUN cycle.
    cpu_run_d = (state_d == RUN);
    done_d    = (state_d == HALT);
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign prog_size  = iptr_q;
  assign data_size  = dptr_q;
  assign cpu_run    = cpu_run_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign run_cycles = run_cycles_q;
  assign state      = state_q;

endmodule

// File: tb/tb_program_load_sequencer.sv
// Bench for program_load_sequencer: vector table, directed corner sequences and
// randomized stimulus, all checked against a cycle-level reference model.
module tb_program_load_sequencer;

  logic        clk;
  logic        reset;
  logic        start_signal;
  logic        add_into;
  logic [31:0] new_instruction;
  logic        in_valid;
  logic        end_signal;

  // Default-sized instance
  logic        a_imem_we, a_dmem_we, a_cpu_run, a_done, a_overflow;
  logic [7:0]  a_imem_addr, a_dmem_addr;
  logic [31:0] a_imem_wdata, a_dmem_wdata, a_run_cycles;
  logic [8:0]  a_prog_size, a_data_size;
  logic [2:0]  a_state;

  // Small instance for full-memory behaviour
  logic        b_imem_we, b_dmem_we, b_cpu_run, b_done, b_overflow;
  logic [2:0]  b_imem_addr, b_dmem_addr;
  logic [31:0] b_imem_wdata, b_dmem_wdata, b_run_cycles;
  logic [3:0]  b_prog_size, b_data_size;
  logic [2:0]  b_state;

  int n_cmp = 0;
  int n_err = 0;

  program_load_sequencer #(.ADDR_W(8), .IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut_a (
    .clk(clk), .reset(reset), .start_signal(start_signal), .add_into(add_into),
    .new_instruction(new_instruction), .in_valid(in_valid), .end_signal(end_signal),
    .imem_we(a_imem_we), .imem_addr(a_imem_addr), .imem_wdata(a_imem_wdata),
    .dmem_we(a_dmem_we), .dmem_addr(a_dmem_addr), .dmem_wdata(a_dmem_wdata),
    .prog_size(a_prog_size), .data_size(a_data_size), .cpu_run(a_cpu_run),
    .done(a_done), .overflow(a_overflow), .run_cycles(a_run_cycles), .state(a_state)
  );

  program_load_sequencer #(.ADDR_W(3), .IMEM_DEPTH(4), .DMEM_DEPTH(6)) dut_b (
    .clk(clk), .reset(reset), .start_signal(start_signal), .add_into(add_into),
    .new_instruction(new_instruction), .in_valid(in_valid), .end_signal(end_signal),
    .imem_we(b_imem_we), .imem_addr(b_imem_addr), .imem_wdata(b_imem_wdata),
    .dmem_we(b_dmem_we), .dmem_addr(b_dmem_addr), .dmem_wdata(b_dmem_wdata),
    .prog_size(b_prog_size), .data_size(b_data_size), .cpu_run(b_cpu_run),
    .done(b_done), .overflow(b_overflow), .run_cycles(b_run_cycles), .state(b_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0=LOAD_I 1=LOAD_D 2=RUN 3=HALT, plus counts and last write.
  typedef struct {
    int          mode;
    int          np;
    int          nd;
    bit          ovf;
    longint      runs;
    bit          we_i;
    int          addr_i;
    logic [31:0] wd_i;
    bit          we_d;
    int          addr_d;
    logic [31:0] wd_d;
  } model_t;

  model_t ma, mb;

  function automatic model_t zero_m();
    model_t z;
    z.mode = 0; z.np = 0; z.nd = 0; z.ovf = 1'b0; z.runs = 0;
    z.we_i = 1'b0; z.addr_i = 0; z.wd_i = 32'd0;
    z.we_d = 1'b0; z.addr_d = 0; z.wd_d = 32'd0;
    return z;
  endfunction

  function automatic model_t step(input model_t m, input int idep, input int ddep,
                                  input logic r, input logic s, input logic a,
                                  input logic v, input logic e, input logic [31:0] d);
    model_t n;
    n = m;
    n.we_i = 1'b0;
    n.we_d = 1'b0;
    if (r) return zero_m();
    if (v && m.mode == 0) begin
      if (m.np < idep) begin
        n.we_i = 1'b1; n.addr_i = m.np; n.wd_i = d; n.np = m.np + 1;
      end else n.ovf = 1'b1;
    end
    if (v && m.mode == 1) begin
      if (m.nd < ddep) begin
        n.we_d = 1'b1; n.addr_d = m.nd; n.wd_d = d; n.nd = m.nd + 1;
      end else n.ovf = 1'b1;
    end
    case (m.mode)
      0, 1: begin
        if (s) n.mode = (m.np > 0) ? 2 : 3;
        else if (m.mode == 0 && a) n.mode = 1;
      end
      2: begin
        if (m.runs < 64'hFFFF_FFFF) n.runs = m.runs + 1;
        if (e) n.mode = 3;
      end
      default: ;
    endcase
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input string tag, input model_t m, input logic [2:0] st,
                           input logic iwe, input logic [63:0] ia, input logic [31:0] iwd,
                           input logic dwe, input logic [63:0] da, input logic [31:0] dwd,
                           input logic [63:0] ps, input logic [63:0] ds, input logic run,
                           input logic dn, input logic ov, input logic [31:0] rc);
    chk({tag, ".state"},      64'(st),  64'(m.mode));
    chk({tag, ".imem_we"},    64'(iwe), 64'(m.we_i));
    chk({tag, ".imem_addr"},  ia,       64'(m.addr_i));
    chk({tag, ".imem_wdata"}, 64'(iwd), 64'(m.wd_i));
    chk({tag, ".dmem_we"},    64'(dwe), 64'(m.we_d));
    chk({tag, ".dmem_addr"},  da,       64'(m.addr_d));
    chk({tag, ".dmem_wdata"}, 64'(dwd), 64'(m.wd_d));
    chk({tag, ".prog_size"},  ps,       64'(m.np));
    chk({tag, ".data_size"},  ds,       64'(m.nd));
    chk({tag, ".cpu_run"},    64'(run), 64'(m.mode == 2));
    chk({tag, ".done"},       64'(dn),  64'(m.mode == 3));
    chk({tag, ".overflow"},   64'(ov),  64'(m.ovf));
    chk({tag, ".run_cycles"}, 64'(rc),  64'(m.runs));
  endtask

  // Drive one cycle of inputs, step both models, then compare at the falling edge.
  task automatic cycle(input logic r, input logic s, input logic a, input logic v,
                       input logic e, input logic [31:0] d);
    reset = r; start_signal = s; add_into = a; in_valid = v; end_signal = e;
    new_instruction = d;
    @(posedge clk);
    ma = step(ma, 256, 256, r, s, a, v, e, d);
    mb = step(mb, 4, 6, r, s, a, v, e, d);
    @(negedge clk);
    cmp_model("A", ma, a_state, a_imem_we, 64'(a_imem_addr), a_imem_wdata, a_dmem_we,
              64'(a_dmem_addr), a_dmem_wdata, 64'(a_prog_size), 64'(a_data_size),
              a_cpu_run, a_done, a_overflow, a_run_cycles);
    cmp_model("B", mb, b_state, b_imem_we, 64'(b_imem_addr), b_imem_wdata, b_dmem_we,
              64'(b_dmem_addr), b_dmem_wdata, 64'(b_prog_size), 64'(b_data_size),
              b_cpu_run, b_done, b_overflow, b_run_cycles);
  endtask

  typedef struct {
    logic r, s, a, v, e;
    logic [31:0] d;
    logic [2:0]  st;
    logic        iwe;
    logic [7:0]  ia;
    logic        dwe;
    logic [7:0]  da;
    logic [8:0]  ps, ds;
    logic        run, dn;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int wcnt;
    ma = zero_m();
    mb = zero_m();
    reset = 1'b1; start_signal = 1'b0; add_into = 1'b0; in_valid = 1'b0;
    end_signal = 1'b0; new_instruction = 32'd0;

    //            r     s     a     v     e     data            st    iwe   ia    dwe   da    ps    ds    run   dn
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'd0, 1'b0, 8'd0, 1'b0, 8'd0, 9'd0, 9'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1111_0001, 3'd0, 1'b1, 8'd0, 1'b0, 8'd0, 9'd1, 9'd0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1111_0002, 3'd1, 1'b1, 8'd1, 1'b0, 8'd0, 9'd2, 9'd0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1111_0003, 3'd1, 1'b0, 8'd0, 1'b1, 8'd0, 9'd2, 9'd1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'd1, 1'b0, 8'd0, 1'b0, 8'd0, 9'd2, 9'd1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1111_0005, 3'd2, 1'b0, 8'd0, 1'b1, 8'd1, 9'd2, 9'd2, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1111_0006, 3'd2, 1'b0, 8'd0, 1'b0, 8'd0, 9'd2, 9'd2, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 3'd3, 1'b0, 8'd0, 1'b0, 8'd0, 9'd2, 9'd2, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1111_0008, 3'd3, 1'b0, 8'd0, 1'b0, 8'd0, 9'd2, 9'd2, 1'b0, 1'b1};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1111_0009, 3'd0, 1'b0, 8'd0, 1'b0, 8'd0, 9'd0, 9'd0, 1'b0, 1'b0};

    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].v, tbl[i].e, tbl[i].d);
      chk($sformatf("tbl%0d.state", i), 64'(a_state), 64'(tbl[i].st));
      chk($sformatf("tbl%0d.imem_we", i), 64'(a_imem_we), 64'(tbl[i].iwe));
      chk($sformatf("tbl%0d.dmem_we", i), 64'(a_dmem_we), 64'(tbl[i].dwe));
      chk($sformatf("tbl%0d.prog_size", i), 64'(a_prog_size), 64'(tbl[i].ps));
      chk($sformatf("tbl%0d.data_size", i), 64'(a_data_size), 64'(tbl[i].ds));
      chk($sformatf("tbl%0d.cpu_run", i), 64'(a_cpu_run), 64'(tbl[i].run));
      chk($sformatf("tbl%0d.done", i), 64'(a_done), 64'(tbl[i].dn));
      if (tbl[i].iwe) begin
        chk($sformatf("tbl%0d.imem_addr", i), 64'(a_imem_addr), 64'(tbl[i].ia));
        chk($sformatf("tbl%0d.imem_wdata", i), 64'(a_imem_wdata), 64'(tbl[i].d));
      end
      if (tbl[i].dwe) begin
        chk($sformatf("tbl%0d.dmem_addr", i), 64'(a_dmem_addr), 64'(tbl[i].da));
        chk($sformatf("tbl%0d.dmem_wdata", i), 64'(a_dmem_wdata), 64'(tbl[i].d));
      end
    end

    // 24 instruction words, switch, 7 data words, start, then 50 RUN cycles
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 24; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA000_0000 + 32'(i));
      chk("load24.imem_we", 64'(a_imem_we), 64'd1);
      chk("load24.imem_addr", 64'(a_imem_addr), 64'(i));
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hD000_0000 + 32'(i));
      chk("load7.dmem_addr", 64'(a_dmem_addr), 64'(i));
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("load.prog_size", 64'(a_prog_size), 64'd24);
    chk("load.data_size", 64'(a_data_size), 64'd7);
    chk("load.cpu_run", 64'(a_cpu_run), 64'd1);
    for (int i = 0; i < 49; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    chk("run50.run_cycles", 64'(a_run_cycles), 64'd50);
    chk("run50.state", 64'(a_state), 64'd3);
    chk("run50.done", 64'(a_done), 64'd1);
    wcnt = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'(i), 1'b1, 1'b0, 32'hBAD0_0000 + 32'(i));
      if (a_imem_we || a_dmem_we) wcnt++;
    end
    chk("halt.writes", 64'(wcnt), 64'd0);
    chk("halt.run_cycles", 64'(a_run_cycles), 64'd50);

    // Start with nothing loaded goes straight to HALT
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("empty.state", 64'(a_state), 64'd3);
    chk("empty.done", 64'(a_done), 64'd1);
    chk("empty.cpu_run", 64'(a_cpu_run), 64'd0);
    chk("empty.run_cycles", 64'(a_run_cycles), 64'd0);

    // Six words into a four-word imem
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    wcnt = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hC000_0000 + 32'(i));
      if (b_imem_we) begin
        chk("ovf.imem_addr", 64'(b_imem_addr), 64'(wcnt));
        wcnt++;
      end
    end
    chk("ovf.writes", 64'(wcnt), 64'd4);
    chk("ovf.prog_size", 64'(b_prog_size), 64'd4);
    chk("ovf.overflow", 64'(b_overflow), 64'd1);

    // Reset mid-RUN with ten words loaded, then reload from address 0
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hE000_0000 + 32'(i));
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    chk("rst.state", 64'(a_state), 64'd0);
    chk("rst.prog_size", 64'(a_prog_size), 64'd0);
    chk("rst.run_cycles", 64'(a_run_cycles), 64'd0);
    chk("rst.cpu_run", 64'(a_cpu_run), 64'd0);
    chk("rst.overflow", 64'(b_overflow), 64'd0);
    chk("rst.imem_addr", 64'(a_imem_addr), 64'd0);
    chk("rst.imem_wdata", 64'(a_imem_wdata), 64'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234_5678);
    chk("reload.imem_we", 64'(a_imem_we), 64'd1);
    chk("reload.imem_addr", 64'(a_imem_addr), 64'd0);

    // Randomized traffic checked against the model on every cycle
    for (int i = 0; i < 4000; i++) begin
      cycle(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) == 0), $urandom());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
